fetch_stage_dual_pe: RTL

Dual-lane instruction fetch stage for the two-PE core. Holds one program counter per processing element, drives the instruction memory's two read-address ports, and registers each returned instruction into a per-lane IF/ID pipeline register for the decode stage. Handles stall, flush and execute-stage redirect independently per lane.

---
 rtl/fetch_stage_dual_pe.sv | 94 +++++++++
 1 files changed

// File: rtl/fetch_stage_dual_pe.sv
// fetch_stage_dual_pe: two independent fetch lanes, each with its own PC and IF/ID register.
// Lane 2 starts in the upper half of the shared instruction store.
module fetch_lane #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall_f,
  input  logic        i_stall_d,
  input  logic        i_flush_d,
  input  logic        i_pc_src_e,
  input  logic [31:0] i_pc_target_e,
  output logic [31:0] o_a,
  input  logic [31:0] i_rd,
  output logic [31:0] o_instr_d,
  output logic [31:0] o_pc_d,
  output logic [31:0] o_pc_plus4_d,
  output logic        o_valid_d
);
  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign o_a        = r_pc;
  // A redirect also squashes the instruction fetched down the wrong path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc          <= PC_RESET;
      o_instr_d     <= NOP_INSTR;
      o_pc_d        <= '0;
      o_pc_plus4_d  <= '0;
      o_valid_d     <= 1'b0;
    end else begin
      r_pc <= i_pc_src_e ? (i_pc_target_e & 32'hFFFF_FFFC) : i_stall_f ? r_pc : w_pc_plus4;
      if (i_flush_d || i_pc_src_e) begin
        o_instr_d    <= NOP_INSTR;
        o_pc_d       <= '0;
        o_pc_plus4_d <= '0;
        o_valid_d    <= 1'b0;
      end else if (!i_stall_d) begin
        o_instr_d    <= i_rd;
        o_pc_d       <= r_pc;
        o_pc_plus4_d <= w_pc_plus4;
        o_valid_d    <= 1'b1;
      end
    end
  end
endmodule

module fetch_stage_dual_pe #(
  parameter logic [31:0] PC1_RESET = 32'h0000_0000,
  parameter logic [31:0] PC2_RESET = 32'h0000_0800,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall_f1,
  input  logic        i_stall_d1,
  input  logic        i_flush_d1,
  input  logic        i_pc_src_e1,
  input  logic [31:0] i_pc_target_e1,
  output logic [31:0] o_a1,
  input  logic [31:0] i_rd1,
  output logic [31:0] o_instr_d1,
  output logic [31:0] o_pc_d1,
  output logic [31:0] o_pc_plus4_d1,
  output logic        o_valid_d1,
  input  logic        i_stall_f2,
  input  logic        i_stall_d2,
  input  logic        i_flush_d2,
  input  logic        i_pc_src_e2,
  input  logic [31:0] i_pc_target_e2,
  output logic [31:0] o_a2,
  input  logic [31:0] i_rd2,
  output logic [31:0] o_instr_d2,
  output logic [31:0] o_pc_d2,
  output logic [31:0] o_pc_plus4_d2,
  output logic        o_valid_d2
);
  fetch_lane #(.PC_RESET(PC1_RESET), .NOP_INSTR(NOP_INSTR)) u_lane1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_stall_f(i_stall_f1), .i_stall_d(i_stall_d1), .i_flush_d(i_flush_d1),
    .i_pc_src_e(i_pc_src_e1), .i_pc_target_e(i_pc_target_e1),
    .o_a(o_a1), .i_rd(i_rd1),
    .o_instr_d(o_instr_d1), .o_pc_d(o_pc_d1), .o_pc_plus4_d(o_pc_plus4_d1), .o_valid_d(o_valid_d1)
  );
  fetch_lane #(.PC_RESET(PC2_RESET), .NOP_INSTR(NOP_INSTR)) u_lane2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_stall_f(i_stall_f2), .i_stall_d(i_stall_d2), .i_flush_d(i_flush_d2),
    .i_pc_src_e(i_pc_src_e2), .i_pc_target_e(i_pc_target_e2),
    .o_a(o_a2), .i_rd(i_rd2),
    .o_instr_d(o_instr_d2), .o_pc_d(o_pc_d2), .o_pc_plus4_d(o_pc_plus4_d2), .o_valid_d(o_valid_d2)
  );
endmodule
